// File: rtl/ic_line_fill.sv
// ic_line_fill: instruction-cache line-fill stage.
// Buffers completed 128-bit lines in a 2-entry FIFO, writes each line into
// the icache data array one 32-bit word per accepted cycle, then writes the
// tag, and hands the missed instruction word to the core.
// Optional feature macro: IC_LINE_FILL_CRIT_FIRST_EN
//   defined   : critical-word-first write order, v_crit_inst with first write
//   undefined : word order 0..3, v_crit_inst in the tag-write cycle
module ic_line_fill #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [127:0]                 inst_word_ic,
  input  logic                         v_inst_word,
  input  logic [ADDR_W-1:0]            miss_addr_ic,
  input  logic                         fill_wr_ready,
  output logic                         fill_wr_en,
  output logic [INDEX_W-1:0]           fill_wr_index,
  output logic [1:0]                   fill_wr_word,
  output logic [31:0]                  fill_wr_data,
  output logic                         tag_wr_en,
  output logic [INDEX_W-1:0]           tag_wr_index,
  output logic [ADDR_W-INDEX_W-5:0]    tag_wr_tag,
  output logic [31:0]                  crit_inst,
  output logic                         v_crit_inst,
  output logic                         line_fill_full,
  output logic                         line_fill_ovf
);

  // One buffered line: four words, line address (addr[ADDR_W-1:4]) and the
  // critical word offset (addr[3:2]).
  typedef struct packed {
    logic [3:0][31:0]  line;
    logic [ADDR_W-5:0] addr;
    logic [1:0]        crit;
  } ent_t;

  typedef enum logic [1:0] {IDLE, WRITE, TAG} state_t;

  ent_t       fifo [2];
  ent_t       head;
  ent_t       new_ent;
  logic       wr_ptr, rd_ptr;
  logic [1:0] count, count_nxt;
  logic       push, pop;
  state_t     state, state_nxt;
  logic [1:0] wcnt, wcnt_nxt;

  assign head    = fifo[rd_ptr];
  assign new_ent = '{line: inst_word_ic, addr: miss_addr_ic[ADDR_W-1:4], crit: miss_addr_ic[3:2]};

  // The head leaves in the TAG cycle, so a push into a full FIFO is legal then.
  assign pop  = (state == TAG);
  assign push = v_inst_word && ((count != 2'd2) || pop);

  // Occupancy after this cycle's push/pop; also drives the TAG exit decision.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  // FIFO storage, pointers, occupancy and the full/overflow flags. Entries
  // are cleared on reset so the head-driven outputs read zero, not X.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) fifo[i] <= '0;
      wr_ptr         <= 1'b0;
      rd_ptr         <= 1'b0;
      count          <= 2'd0;
      line_fill_full <= 1'b0;
      line_fill_ovf  <= 1'b0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= new_ent;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count          <= count_nxt;
      line_fill_full <= (count_nxt == 2'd2);
      if (v_inst_word && !push) line_fill_ovf <= 1'b1;
    end
  end

  // FSM state and word counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      wcnt  <= 2'd0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Next-state and strobes: four accepted word writes, then one tag write.
  // A stalled WRITE holds wcnt so word/data stay put until accepted.
  always_comb begin
    state_nxt  = state;
    wcnt_nxt   = wcnt;
    fill_wr_en = 1'b0;
    tag_wr_en  = 1'b0;
    case (state)
      IDLE: begin
        if (count != 2'd0) begin
          state_nxt = WRITE;
          wcnt_nxt  = 2'd0;
        end
      end
      WRITE: begin
        fill_wr_en = fill_wr_ready;
        if (fill_wr_ready) begin
          wcnt_nxt = wcnt + 2'd1;
          if (wcnt == 2'd3) state_nxt = TAG;
        end
      end
      TAG: begin
        tag_wr_en = 1'b1;
        wcnt_nxt  = 2'd0;
        state_nxt = (count_nxt != 2'd0) ? WRITE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Word selection and critical-word strobe; data/index always come from the
  // head entry so idle outputs are defined.
  always_comb begin
`ifdef IC_LINE_FILL_CRIT_FIRST_EN
    fill_wr_word = head.crit + wcnt;
    v_crit_inst  = (state == WRITE) && fill_wr_ready && (wcnt == 2'd0);
`else
    fill_wr_word = wcnt;
    v_crit_inst  = (state == TAG);
`endif
    fill_wr_data  = head.line[fill_wr_word];
    crit_inst     = head.line[head.crit];
    fill_wr_index = head.addr[INDEX_W-1:0];
    tag_wr_index  = head.addr[INDEX_W-1:0];
    tag_wr_tag    = head.addr[ADDR_W-5:INDEX_W];
  end

endmodule

// File: tb/tb_ic_line_fill.sv
// Bench for ic_line_fill: directed scenarios plus random traffic, checked
// against a queue-of-lines reference model.
module tb_ic_line_fill;
  localparam int ADDR_W  = 32;
  localparam int INDEX_W = 6;
  localparam int TAG_W   = ADDR_W - INDEX_W - 4;
  localparam int NSNAP   = 2048;
`ifdef IC_LINE_FILL_CRIT_FIRST_EN
  localparam bit CF = 1'b1;
`else
  localparam bit CF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [127:0] inst_word_ic;
  logic v_inst_word;
  logic [31:0] miss_addr_ic;
  logic fill_wr_ready;
  logic fill_wr_en;
  logic [INDEX_W-1:0] fill_wr_index;
  logic [1:0] fill_wr_word;
  logic [31:0] fill_wr_data;
  logic tag_wr_en;
  logic [INDEX_W-1:0] tag_wr_index;
  logic [TAG_W-1:0] tag_wr_tag;
  logic [31:0] crit_inst;
  logic v_crit_inst, line_fill_full, line_fill_ovf;

  ic_line_fill #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W)) dut (
    .clk(clk), .rst(rst), .inst_word_ic(inst_word_ic), .v_inst_word(v_inst_word),
    .miss_addr_ic(miss_addr_ic), .fill_wr_ready(fill_wr_ready), .fill_wr_en(fill_wr_en),
    .fill_wr_index(fill_wr_index), .fill_wr_word(fill_wr_word), .fill_wr_data(fill_wr_data),
    .tag_wr_en(tag_wr_en), .tag_wr_index(tag_wr_index), .tag_wr_tag(tag_wr_tag),
    .crit_inst(crit_inst), .v_crit_inst(v_crit_inst), .line_fill_full(line_fill_full),
    .line_fill_ovf(line_fill_ovf));

  always #5 clk = ~clk;

  typedef struct { logic [127:0] line; logic [31:0] addr; } line_t;
  line_t lq[$];
  int    wdone;
  logic  exp_full, exp_ovf;
  int    cyc, n_assert, n_fail;

  logic        snap_en[NSNAP], snap_tag[NSNAP], snap_vc[NSNAP], snap_full[NSNAP], snap_ovf[NSNAP];
  logic [1:0]  snap_word[NSNAP];
  logic [31:0] snap_data[NSNAP], snap_crit[NSNAP];

  function automatic logic [31:0] word_of(input logic [127:0] ln, input int k);
    return ln[32*k +: 32];
  endfunction

  // k-th word written for a line whose missed word is c
  function automatic int ord(input logic [1:0] c, input int k);
    if (CF) return (int'(c) + k) % 4;
    return k;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst(input string p);
    chk({p, "_wr_en"}, fill_wr_en, 0);
    chk({p, "_tag_en"}, tag_wr_en, 0);
    chk({p, "_vcrit"}, v_crit_inst, 0);
    chk({p, "_full"}, line_fill_full, 0);
    chk({p, "_ovf"}, line_fill_ovf, 0);
    chk({p, "_crit"}, crit_inst, 0);
    chk({p, "_idx"}, fill_wr_index, 0);
    chk({p, "_word"}, fill_wr_word, 0);
    chk({p, "_data"}, fill_wr_data, 0);
    chk({p, "_tidx"}, tag_wr_index, 0);
    chk({p, "_tag"}, tag_wr_tag, 0);
  endtask

  // Check one cycle's outputs against the model, then advance the model.
  task automatic monitor(input logic v, input logic [127:0] ln, input logic [31:0] ad, input logic r);
    logic ev; logic [31:0] ec; logic popq; int k; line_t h;
    ev = 1'b0; ec = '0; popq = 1'b0;
    if (cyc < NSNAP) begin
      snap_en[cyc] = fill_wr_en;    snap_tag[cyc] = tag_wr_en;  snap_vc[cyc] = v_crit_inst;
      snap_full[cyc] = line_fill_full; snap_ovf[cyc] = line_fill_ovf;
      snap_word[cyc] = fill_wr_word; snap_data[cyc] = fill_wr_data; snap_crit[cyc] = crit_inst;
    end
    chk("full", line_fill_full, exp_full);
    chk("ovf", line_fill_ovf, exp_ovf);
    chk("no_x", $isunknown({fill_wr_en, fill_wr_index, fill_wr_word, fill_wr_data, tag_wr_en,
                            tag_wr_index, tag_wr_tag, crit_inst, v_crit_inst}), 0);
    if (fill_wr_en) begin
      chk("wr_needs_ready", fill_wr_ready, 1);
      chk("wr_has_line", (lq.size() > 0 && wdone < 4), 1);
      if (lq.size() > 0 && wdone < 4) begin
        h = lq[0];
        k = ord(h.addr[3:2], wdone);
        chk("wr_word", fill_wr_word, k);
        chk("wr_data", fill_wr_data, word_of(h.line, k));
        chk("wr_index", fill_wr_index, h.addr[9:4]);
        if (CF && wdone == 0) begin ev = 1'b1; ec = word_of(h.line, k); end
        wdone++;
      end
    end
    if (tag_wr_en) begin
      chk("tag_excl", fill_wr_en, 0);
      chk("tag_after_4", (lq.size() > 0 && wdone == 4), 1);
      if (lq.size() > 0) begin
        h = lq[0];
        chk("tag_index", tag_wr_index, h.addr[9:4]);
        chk("tag_value", tag_wr_tag, h.addr[31:10]);
        if (!CF) begin ev = 1'b1; ec = word_of(h.line, int'(h.addr[3:2])); end
        popq = 1'b1;
      end
    end
    chk("v_crit", v_crit_inst, ev);
    if (ev) chk("crit_inst", crit_inst, ec);
    if (!r) begin
      lq.delete(); wdone = 0; exp_full = 1'b0; exp_ovf = 1'b0;
    end else begin
      if (popq) begin void'(lq.pop_front()); wdone = 0; end
      if (v) begin
        if (lq.size() < 2) lq.push_back('{ln, ad});
        else exp_ovf = 1'b1;
      end
      exp_full = (lq.size() == 2);
    end
  endtask

  // Drive one cycle's inputs, check mid-cycle, move to the next cycle.
  task automatic step(input logic v, input logic [127:0] ln, input logic [31:0] ad,
                      input logic rdy, input logic r);
    rst = r; v_inst_word = v; inst_word_ic = ln; miss_addr_ic = ad; fill_wr_ready = rdy;
    #2;
    monitor(v, ln, ad, r);
    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    logic [127:0] l1, l2, l3, l4, l5, l6, l7;
    logic [31:0]  a1, a2, a3, a4, a5, a6, a7;
    int t, guard;
    n_assert = 0; n_fail = 0; cyc = 0; wdone = 0; exp_full = 1'b0; exp_ovf = 1'b0;
    rst = 1'b0; v_inst_word = 1'b0; inst_word_ic = '0; miss_addr_ic = '0; fill_wr_ready = 1'b0;
    @(posedge clk); #1;

    // reset state
    step(0, '0, '0, 1, 0);
    chk_rst("rst0");

    // single line, no backpressure
    l1 = 128'h33333333_22222222_11111111_00000000; a1 = 32'h0000_0128;
    t = cyc;
    step(1, l1, a1, 1, 1);
    repeat (8) step(0, '0, '0, 1, 1);
    chk("s_no_wr_t1", snap_en[t+1], 0);
    chk("s_wr_t2", snap_en[t+2], 1);
    chk("s_word_t2", snap_word[t+2], CF ? 2 : 0);
    chk("s_data_t2", snap_data[t+2], CF ? 32'h22222222 : 32'h00000000);
    chk("s_word_t3", snap_word[t+3], CF ? 3 : 1);
    chk("s_wr_t5", snap_en[t+5], 1);
    chk("s_no_wr_t6", snap_en[t+6], 0);
    chk("s_tag_t6", snap_tag[t+6], 1);
    chk("s_vcrit", snap_vc[CF ? t+2 : t+6], 1);
    chk("s_crit", snap_crit[CF ? t+2 : t+6], 32'h22222222);

    // backpressure: ready low for 3 cycles after the first write
    l2 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA; a2 = 32'h0000_5674;
    t = cyc;
    step(1, l2, a2, 1, 1);
    repeat (2) step(0, '0, '0, 1, 1);
    repeat (3) step(0, '0, '0, 0, 1);
    repeat (7) step(0, '0, '0, 1, 1);
    for (int i = 3; i <= 5; i++) begin
      chk("b_stall_en", snap_en[t+i], 0);
      chk("b_stall_word", snap_word[t+i], CF ? 2 : 1);
      chk("b_stall_data", snap_data[t+i], CF ? 32'hCCCCCCCC : 32'hBBBBBBBB);
    end
    chk("b_no_tag_t8", snap_tag[t+8], 0);
    chk("b_tag_t9", snap_tag[t+9], 1);

    // two lines back-to-back
    l3 = {$urandom(), $urandom(), $urandom(), $urandom()}; a3 = 32'h0000_0A34;
    l4 = {$urandom(), $urandom(), $urandom(), $urandom()}; a4 = 32'h1234_5678;
    t = cyc;
    step(1, l3, a3, 1, 1);
    step(1, l4, a4, 1, 1);
    repeat (12) step(0, '0, '0, 1, 1);
    chk("bb_full_t1", snap_full[t+1], 0);
    chk("bb_full_t2", snap_full[t+2], 1);
    chk("bb_tag1_t6", snap_tag[t+6], 1);
    chk("bb_wr2_t7", snap_en[t+7], 1);
    chk("bb_word2_t7", snap_word[t+7], CF ? 2 : 0);
    chk("bb_data2_t7", snap_data[t+7], word_of(l4, CF ? 2 : 0));
    chk("bb_tag2_t11", snap_tag[t+11], 1);

    // overflow: third push while full with no pop is dropped
    l5 = {$urandom(), $urandom(), $urandom(), $urandom()}; a5 = 32'h0000_1F3C;
    l6 = {$urandom(), $urandom(), $urandom(), $urandom()}; a6 = 32'h00AB_C010;
    l7 = {$urandom(), $urandom(), $urandom(), $urandom()}; a7 = 32'h0000_0200;
    t = cyc;
    step(1, l5, a5, 1, 1);
    step(1, l6, a6, 1, 1);
    step(1, l7, a7, 1, 1);
    repeat (14) step(0, '0, '0, 1, 1);
    chk("o_ovf_t2", snap_ovf[t+2], 0);
    chk("o_ovf_t3", snap_ovf[t+3], 1);
    chk("o_data2_t7", snap_data[t+7], word_of(l6, ord(a6[3:2], 0)));
    chk("o_ovf_sticky", line_fill_ovf, 1);

    // reset after two writes of a line
    t = cyc;
    step(1, l1, a1, 1, 1);
    repeat (3) step(0, '0, '0, 1, 1);
    step(0, '0, '0, 0, 0);
    chk_rst("mid_rst");
    step(0, '0, '0, 1, 0);
    repeat (10) step(0, '0, '0, 1, 1);
    for (int i = 4; i <= t + 15 - t; i++) chk("r_no_tag", snap_tag[t+i], 0);
    t = cyc;
    step(1, l2, a2, 1, 1);
    repeat (8) step(0, '0, '0, 1, 1);
    chk("r_new_wr_t2", snap_en[t+2], 1);
    chk("r_new_tag_t6", snap_tag[t+6], 1);

    // random traffic against the model
    repeat (250)
      step($urandom_range(0, 99) < 35, {$urandom(), $urandom(), $urandom(), $urandom()},
           $urandom(), $urandom_range(0, 99) < 70, 1);
    guard = 0;
    while (lq.size() > 0 && guard < 60) begin
      step(0, '0, '0, 1, 1);
      guard++;
    end
    chk("drain", lq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/ic_line_fill.md
# ic_line_fill

Instruction-cache line-fill stage that sits directly downstream of the instruction download stage. It captures each completed 128-bit instruction line (from local memory or reassembled from rep flits) with its miss address and buffers it in a 2-entry line FIFO. It writes the line into the icache data array one 32-bit word per accepted cycle, then writes the tag. It also hands the critical (missed) instruction word to the core.

## Interface
Parameters:
- ADDR_W, 32, byte-address width.
- INDEX_W, 6, icache set-index width. Index is addr[INDEX_W+3:4]; tag is addr[ADDR_W-1:INDEX_W+4].

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- inst_word_ic  in  128  completed line. Word k = bits [32k+31:32k].
- v_inst_word  in  1  one-cycle pulse: inst_word_ic and miss_addr_ic are valid.
- miss_addr_ic  in  ADDR_W  miss address of the line, sampled with v_inst_word.
- fill_wr_ready  in  1  icache data port free this cycle.
- fill_wr_en  out  1  data-array word write strobe.
- fill_wr_index  out  INDEX_W  set index of the write.
- fill_wr_word  out  2  word offset within the line.
- fill_wr_data  out  32  word data.
- tag_wr_en  out  1  one-cycle tag/valid write strobe.
- tag_wr_index  out  INDEX_W  set index for the tag write.
- tag_wr_tag  out  ADDR_W-INDEX_W-4  tag value.
- crit_inst  out  32  critical instruction word (word addr[3:2]).
- v_crit_inst  out  1  one-cycle pulse: crit_inst is valid.
- line_fill_full  out  1  both FIFO entries occupied; upstream must not pulse v_inst_word.
- line_fill_ovf  out  1  sticky: a push was dropped because the FIFO was full.

## Operation
- **FIFO:** 2 entries, each holding {line[127:0], addr[ADDR_W-1:4], crit[1:0]=addr[3:2]}. It uses wr_ptr, rd_ptr and a 2-bit count.
  - Push on v_inst_word when count<2, or when count==2 and a pop occurs in the same cycle.
  - Any other push while full is dropped and sets line_fill_ovf. line_fill_ovf is cleared only by reset.
- **FSM states:** IDLE, WRITE, TAG.
  - IDLE: if count!=0, go to WRITE and clear word counter wcnt (2 bits).
  - WRITE: fill_wr_en = fill_wr_ready (combinational, qualified by state).
    - Each accepted write increments wcnt.
    - On the 4th accepted write (wcnt==3 && fill_wr_ready), go to TAG.
    - When fill_wr_ready=0, the FSM stays in WRITE, holds wcnt, and keeps the outputs stable.
  - TAG: assert tag_wr_en and pop the head entry.
    - Go to WRITE (wcnt cleared) if count after the pop is nonzero; otherwise go to IDLE.
- **Word order:** fill_wr_word = crit + wcnt (mod 4, wrap-around), i.e. critical word first. fill_wr_data = head line word[fill_wr_word].
- **Critical word:** v_crit_inst pulses in the cycle of the first accepted write (wcnt==0), with crit_inst = that word.
- fill_wr_index and tag_wr_index come from the head entry's address; tag_wr_tag is the head entry's tag.
- **Outputs when not active:** all strobes are 0. Data and index outputs are don't-care but must be driven from the head entry (no X).
- **Reset mid-operation:** FIFO emptied, pointers and count set to 0, FSM to IDLE, wcnt to 0. A partially written line is abandoned with no tag write, so the set stays invalid.

## Timing
- Reset values: fill_wr_en=0, tag_wr_en=0, v_crit_inst=0, line_fill_full=0, line_fill_ovf=0, crit_inst=0, all index/word/data/tag outputs=0.
- v_inst_word in cycle t → entry visible (count=1) in t+1 → FSM in WRITE in t+2.
- With fill_wr_ready held high:
  - data writes occur in t+2..t+5;
  - v_crit_inst pulses in t+2;
  - tag_wr_en pulses in t+6.
- Back-to-back lines: the next line's first write occurs in the cycle after TAG, so there are no idle cycles between lines.
- Each cycle with fill_wr_ready low adds one cycle of latency.
- line_fill_full is registered from count: it is high in the cycle after the second push.
- A push and a pop in the same cycle leave count unchanged.

## Configuration
- IC_LINE_FILL_CRIT_FIRST_EN defined:
  - critical-word-first order as above;
  - v_crit_inst fires with the first data write.
- Not defined:
  - fill_wr_word = wcnt (order 0,1,2,3);
  - v_crit_inst fires in the TAG cycle, with crit_inst = word[crit] of the head entry.

## Test plan
- **Single line, no backpressure:** line 128'h33333333_22222222_11111111_00000000 with addr 32'h0000_0128.
  - Writes occur in t+2..t+5 with words 2,3,0,1 and data 22222222, 33333333, 00000000, 11111111, all at index 0x12.
  - v_crit_inst at t+2 with crit_inst 32'h22222222.
  - tag_wr_en at t+6 with tag 32'h0000_0128>>10 = 0x0.
- **Backpressure:** fill_wr_ready low for 3 cycles after the first write.
  - wcnt holds and the word/data outputs stay stable.
  - tag_wr_en is delayed to t+9.
- **Two lines back-to-back:** pushes in t and t+1.
  - line_fill_full goes high in t+2.
  - The second line's first write occurs at t+7, immediately after the first TAG.
- **Overflow:** a third push while full with no pop.
  - The push is dropped, line_fill_ovf goes to 1 and stays 1.
  - The two queued lines are written intact.
- **Reset mid-line:** rst=0 after 2 writes.
  - No tag_wr_en occurs; all outputs return to their reset values.
  - A new line after reset completes normally.
- **Macro undefined:** the same stimulus as the single-line test gives word order 0,1,2,3; v_crit_inst at t+6 with crit_inst 32'h22222222.
